// File: rtl/lemming_dig_arbiter_if.sv
// Shovel arbitration bundle between lemmings and the arbiter.
// Master drives requests/releases, slave returns the grant view.
interface lemming_dig_arbiter_if;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] gnt;
  logic [1:0] owner;
  logic       busy;
  logic       revoke;
  logic [7:0] grant_cnt;

  modport master (
    output req,
    output done,
    input  gnt,
    input  owner,
    input  busy,
    input  revoke,
    input  grant_cnt
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output owner,
    output busy,
    output revoke,
    output grant_cnt
  );
endinterface

// File: rtl/lemming_dig_arbiter.sv
// Round-robin shovel arbiter for four lemmings with hold timeout
// and a one-cycle cooldown between consecutive grants.
module lemming_dig_arbiter #(
  parameter int unsigned MAX_HOLD = 20
) (
  input logic                  clk,
  input logic                  areset_n,
  lemming_dig_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_COOL  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] last_q, last_d;
  logic       revoke_q, revoke_d;
  logic [7:0] grant_cnt_q, grant_cnt_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;

  logic       pick_vld;
  logic [1:0] pick_idx;
  logic [1:0] scan_idx;
  logic       own_rel;
  logic       hold_max;

  // First requester after the last winner, wrapping around.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = last_q;
    scan_idx = last_q;
    for (int i = 1; i <= 4; i++) begin
      scan_idx = last_q + 2'(i);
      if (!pick_vld && bus.req[scan_idx]) begin
        pick_vld = 1'b1;
        pick_idx = scan_idx;
      end
    end
  end

  assign own_rel  = bus.done[owner_q] | ~bus.req[owner_q];
  assign hold_max = (hold_cnt_q == 8'(MAX_HOLD));

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    owner_d     = owner_q;
    last_d      = last_q;
    revoke_d    = 1'b0;
    grant_cnt_d = grant_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        gnt_d = 4'b0000;
        if (pick_vld) begin
          state_d    = S_GRANT;
          gnt_d      = 4'b0001 << pick_idx;
          owner_d    = pick_idx;
          last_d     = pick_idx;
          hold_cnt_d = 8'd1;
          if (grant_cnt_q != 8'hFF)
            grant_cnt_d = grant_cnt_q + 8'd1;
        end
      end
      S_GRANT: begin
        if (own_rel) begin
          state_d = S_COOL;
          gnt_d   = 4'b0000;
        end else if (hold_max) begin
          state_d  = S_COOL;
          gnt_d    = 4'b0000;
          revoke_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      S_COOL: begin
        state_d = S_IDLE;
        gnt_d   = 4'b0000;
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  // State and output registers; reset gives lemming 0 first turn.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q     <= S_IDLE;
      gnt_q       <= 4'b0000;
      owner_q     <= 2'd0;
      last_q      <= 2'd3;
      revoke_q    <= 1'b0;
      grant_cnt_q <= 8'd0;
      hold_cnt_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      revoke_q    <= revoke_d;
      grant_cnt_q <= grant_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.owner     = owner_q;
  assign bus.busy      = (state_q == S_GRANT);
  assign bus.revoke    = revoke_q;
  assign bus.grant_cnt = grant_cnt_q;

endmodule

// File: tb/tb_lemming_dig_arbiter.sv
// Directed bench for the shovel arbiter: rotation, release,
// timeout, wrap, async reset and grant counter saturation.
module tb_lemming_dig_arbiter;

  logic clk;
  logic areset_n;
  int   n_tests;
  int   n_fail;
  int   n;

  lemming_dig_arbiter_if bus ();

  lemming_dig_arbiter #(.MAX_HOLD(20)) dut (
    .clk      (clk),
    .areset_n (areset_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    areset_n = 1'b0;
    bus.req  = 4'b0000;
    bus.done = 4'b0000;
    @(negedge clk);
    areset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    areset_n = 1'b1;
    bus.req  = 4'b0000;
    bus.done = 4'b0000;
    #2;
    areset_n = 1'b0;
    #1;
    chk("rst_gnt", 32'(bus.gnt), 0);
    chk("rst_owner", 32'(bus.owner), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_revoke", 32'(bus.revoke), 0);
    chk("rst_cnt", 32'(bus.grant_cnt), 0);

    // Full rotation with timeouts
    do_reset();
    bus.req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      chk("rr_gnt", 32'(bus.gnt), 32'(1 << (g % 4)));
      chk("rr_owner", 32'(bus.owner), 32'(g % 4));
      chk("rr_busy", 32'(bus.busy), 1);
      n = 0;
      while (bus.gnt != 4'b0000 && n < 100) begin
        n++;
        tick();
      end
      chk("rr_hold", n, 20);
      chk("rr_revoke", 32'(bus.revoke), 1);
      tick();
      chk("rr_idle_gnt", 32'(bus.gnt), 0);
      chk("rr_idle_rev", 32'(bus.revoke), 0);
    end
    chk("rr_cnt", 32'(bus.grant_cnt), 5);

    // Voluntary release after 5 cycles
    do_reset();
    bus.req = 4'b0100;
    tick();
    chk("rel_gnt", 32'(bus.gnt), 32'h4);
    n = 1;
    repeat (4) begin
      tick();
      if (bus.gnt == 4'b0100) n++;
    end
    bus.done = 4'b0100;
    tick();
    chk("rel_len", n, 5);
    chk("rel_off", 32'(bus.gnt), 0);
    chk("rel_rev", 32'(bus.revoke), 0);
    chk("rel_cnt", 32'(bus.grant_cnt), 1);
    bus.req  = 4'b0000;
    bus.done = 4'b0000;

    // Release on the timeout edge wins over revoke
    do_reset();
    bus.req = 4'b0010;
    tick();
    chk("tie_owner", 32'(bus.owner), 1);
    repeat (19) tick();
    chk("tie_hold", 32'(bus.gnt), 32'h2);
    bus.done = 4'b0010;
    tick();
    chk("tie_off", 32'(bus.gnt), 0);
    chk("tie_rev", 32'(bus.revoke), 0);
    chk("tie_busy", 32'(bus.busy), 0);
    bus.req  = 4'b0000;
    bus.done = 4'b0000;
    tick();
    chk("tie_rev2", 32'(bus.revoke), 0);

    // Wrap from lemming 3 to 0, then 1, then skip 2
    do_reset();
    bus.req = 4'b1000;
    tick();
    chk("wrap_g3", 32'(bus.gnt), 32'h8);
    bus.req  = 4'b1011;
    bus.done = 4'b1000;
    tick();
    bus.done = 4'b0000;
    tick();
    chk("wrap_gap", 32'(bus.gnt), 0);
    tick();
    chk("wrap_g0", 32'(bus.gnt), 32'h1);
    bus.done = 4'b0001;
    tick();
    bus.done = 4'b0000;
    tick();
    tick();
    chk("wrap_g1", 32'(bus.gnt), 32'h2);
    bus.done = 4'b0010;
    tick();
    bus.done = 4'b0000;
    tick();
    tick();
    chk("wrap_g3b", 32'(bus.gnt), 32'h8);

    // Async reset in the middle of a grant
    #2;
    areset_n = 1'b0;
    #1;
    chk("mid_gnt", 32'(bus.gnt), 0);
    chk("mid_busy", 32'(bus.busy), 0);
    chk("mid_rev", 32'(bus.revoke), 0);
    chk("mid_cnt", 32'(bus.grant_cnt), 0);
    chk("mid_owner", 32'(bus.owner), 0);
    bus.req  = 4'b0110;
    bus.done = 4'b0000;
    @(negedge clk);
    areset_n = 1'b1;
    tick();
    chk("mid_regnt", 32'(bus.gnt), 32'h2);
    chk("mid_cnt1", 32'(bus.grant_cnt), 1);

    // Counter saturation over 300 short grants
    do_reset();
    bus.req  = 4'b1111;
    bus.done = 4'b1111;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (k == 253)
        chk("sat_254", 32'(bus.grant_cnt), 254);
      if (k == 254 || k == 255)
        chk("sat_255", 32'(bus.grant_cnt), 255);
      if (k == 299) begin
        chk("sat_end", 32'(bus.grant_cnt), 255);
        chk("sat_gnt", 32'(bus.gnt), 32'h8);
      end
      tick();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lemming_dig_arbiter.md
LEMMING_DIG_ARBITER -- requirements
Module: lemming_dig_arbiter

Interface
REQ-001 Parameter MAX_HOLD, 20, max consecutive cycles one lemming may hold the shovel (legal range 2..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 areset_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  4  per-lemming dig request; bit i = lemming i wants the shovel.
REQ-005 done  input  4  per-lemming release; bit i = lemming i stopped digging (fell or finished).
REQ-006 gnt  output  4  one-hot shovel grant, registered; all-zero when no owner.
REQ-007 owner  output  2  index of current or last granted lemming, registered.
REQ-008 busy  output  1  high while any gnt bit is high.
REQ-009 revoke  output  1  one-cycle pulse when a grant is ended by timeout.
REQ-010 grant_cnt  output  8  total grants issued since reset, saturating.

Function
REQ-011 The block SHALL implement three states: IDLE, GRANT, COOLDOWN.
REQ-012 In IDLE with req != 0, the block SHALL select the first set req bit scanning from (last+1) mod 4 upward with wrap, enter GRANT, and set gnt/owner at that edge (1-cycle latency from req sample to gnt high).
REQ-013 In IDLE with req == 0, the block SHALL stay in IDLE, gnt = 0.
REQ-014 On each grant, last SHALL be set to the granted index, hold_cnt SHALL clear to 1, and grant_cnt SHALL increment unless it equals 255.
REQ-015 In GRANT, exactly one gnt bit (gnt[owner]) SHALL be high; req/done bits of non-owners SHALL be ignored.
REQ-016 In GRANT, if done[owner] = 1 or req[owner] = 0 at a rising edge, the block SHALL enter COOLDOWN with gnt = 0 and revoke = 0.
REQ-017 In GRANT, if neither release condition holds and hold_cnt = MAX_HOLD, the block SHALL enter COOLDOWN with gnt = 0 and revoke = 1; gnt is thus high exactly MAX_HOLD cycles.
REQ-018 Otherwise in GRANT, hold_cnt SHALL increment and state SHALL remain GRANT.
REQ-019 Simultaneous done[owner] and timeout: voluntary release wins, revoke = 0.
REQ-020 COOLDOWN SHALL last exactly one cycle with gnt = 0, then go to IDLE; req is not arbitrated in COOLDOWN.
REQ-021 revoke SHALL be high only during the COOLDOWN cycle following a timeout.
REQ-022 busy SHALL equal (state == GRANT); owner SHALL hold its value outside GRANT.
REQ-023 Minimum turnaround between two grants SHALL be 2 cycles of gnt = 0 (COOLDOWN + IDLE).
REQ-024 Illegal state encodings SHALL return to IDLE on the next edge with gnt = 0.

Reset
REQ-025 areset_n low SHALL immediately force state = IDLE, gnt = 0, owner = 0, busy = 0, revoke = 0, grant_cnt = 0, hold_cnt = 0, last = 3 (lemming 0 has first priority).
REQ-026 Reset asserted mid-GRANT SHALL drop gnt asynchronously without a revoke pulse.
REQ-027 After areset_n deasserts, the first edge SHALL arbitrate normally from IDLE.

Verification
REQ-028 Reset, then req = 4'b1111 held, done = 0 -> grants in order 0,1,2,3,0, each gnt high 20 cycles, revoke pulse after each, 2 zero cycles between grants.
REQ-029 req = 4'b0100 only, done[2] pulsed 5 cycles after gnt -> gnt = 4'b0100 for exactly 5 cycles, revoke = 0, grant_cnt = 1.
REQ-030 Owner 1 granted, req[1] and done[1] asserted on the edge where hold_cnt = 20 -> release, revoke = 0.
REQ-031 Owner 3 granted, req = 4'b1011 at next IDLE after last = 3 -> wrap, lemming 0 granted; then 1, skipping 2.
REQ-032 areset_n pulsed low mid-GRANT -> gnt = 0 immediately, grant_cnt = 0, next grant to lowest-index requester from 0.
REQ-033 300 back-to-back single-cycle grants -> grant_cnt saturates at 255, arbitration continues.
